// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Programmable interval timer for the CPU register bus. A prescaler divides
//   clk down to ticks, and a DW-bit counter counts ticks up to a compare value.
//   On a compare match the PENDING flag is set, which drives a maskable
//   interrupt. The timer runs in either periodic or one-shot mode, sequenced by
//   an IDLE/RUN/DONE state machine.
//
// Ports
//   clk      : system clock (posedge)
//   rst      : asynchronous reset, active-low
//   wr_en    : register write strobe (one clk per write)
//   rd_en    : register read strobe
//   addr     : 0=CTRL 1=PRESC 2=CMP 3=CNT
//   wdata    : write data
//   rdata    : registered read data, held between reads
//   irq_ack  : one-clk pulse that clears PENDING
//   irq      : registered PENDING & IRQ_EN
//   tick_out : registered one-clk pulse per prescaler tick (RUN only)
//
// CTRL layout: b0 EN, b1 PERIODIC, b2 IRQ_EN, b8 PENDING (write 1 to clear),
//              b9 DONE (read-only). EN reads back as "state is RUN".
// DW must be at least 10 so that the CTRL status bits fit.
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter int DW        = 16,
  parameter int PRESC_RST = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic          irq_ack,
  output logic          irq,
  output logic          tick_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          per_q, per_d;
  logic          irqen_q, irqen_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] presc_q, presc_d;
  logic [DW-1:0] cmp_q, cmp_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic          tick_out_q, tick_out_d;

  logic          ctrl_wr, presc_wr, cmp_wr, cnt_wr;
  logic          tick, match;
  logic [DW-1:0] ctrl_rd;

  assign ctrl_wr  = wr_en && (addr == 2'd0);
  assign presc_wr = wr_en && (addr == 2'd1);
  assign cmp_wr   = wr_en && (addr == 2'd2);
  assign cnt_wr   = wr_en && (addr == 2'd3);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state. A CTRL write always decides the state from the written
  // EN bit, so writing EN=0 in the match clk still lands in IDLE.
  always_comb begin
    state_d = state_q;
    if (ctrl_wr)
      state_d = wdata[0] ? S_RUN : S_IDLE;
    else if (match && !per_q)
      state_d = S_DONE;
  end

  // FSM: outputs. Ticks and matches only happen while running.
  always_comb begin
    tick  = (state_q == S_RUN) && (pcnt_q == presc_q);
    match = tick && (cnt_q == cmp_q);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = (state_q == S_RUN);
    ctrl_rd[1] = per_q;
    ctrl_rd[2] = irqen_q;
    ctrl_rd[8] = pending_q;
    ctrl_rd[9] = (state_q == S_DONE);

    per_d   = ctrl_wr ? wdata[1] : per_q;
    irqen_d = ctrl_wr ? wdata[2] : irqen_q;
    presc_d = presc_wr ? wdata : presc_q;
    cmp_d   = cmp_wr ? wdata : cmp_q;

    // A bus write to CNT overrides the tick in the same clk.
    if (cnt_wr)     cnt_d = wdata;
    else if (match) cnt_d = '0;
    else if (tick)  cnt_d = cnt_q + 1'b1;
    else            cnt_d = cnt_q;

    // The prescaler restarts from 0 whenever RUN is entered or left, on a
    // PRESC write, and after each tick.
    if (state_q != S_RUN || state_d != S_RUN || presc_wr || tick)
      pcnt_d = '0;
    else
      pcnt_d = pcnt_q + 1'b1;

    // Setting PENDING takes priority over any clear in the same clk.
    if (match)                            pending_d = 1'b1;
    else if (irq_ack || (ctrl_wr && wdata[8])) pending_d = 1'b0;
    else                                  pending_d = pending_q;

    irq_d      = pending_q & irqen_q;
    tick_out_d = tick;

    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        2'd0:    rdata_d = ctrl_rd;
        2'd1:    rdata_d = presc_q;
        2'd2:    rdata_d = cmp_q;
        default: rdata_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_q      <= 1'b0;
      irqen_q    <= 1'b0;
      pending_q  <= 1'b0;
      presc_q    <= DW'(PRESC_RST);
      cmp_q      <= '1;
      cnt_q      <= '0;
      pcnt_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      tick_out_q <= 1'b0;
    end else begin
      per_q      <= per_d;
      irqen_q    <= irqen_d;
      pending_q  <= pending_d;
      presc_q    <= presc_d;
      cmp_q      <= cmp_d;
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      tick_out_q <= tick_out_d;
    end
  end

  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign tick_out = tick_out_q;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, irq_ack;
  logic [1:0]    addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          irq, tick_out;

  int checks = 0;
  int failures = 0;

  timer_ctrl #(.DW(DW), .PRESC_RST(50000)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq_ack  (irq_ack),
    .irq      (irq),
    .tick_out (tick_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [DW-1:0] d);
    rd_en = 1'b1; addr = a;
    step(1);
    rd_en = 1'b0;
    d = rdata;
  endtask

  logic [DW-1:0] v;

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; irq_ack = 1'b0;
    addr = '0; wdata = '0;
    step(2);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_tick", 32'(tick_out), 32'h0);
    rst = 1'b1;
    step(1);

    // ---- periodic: PRESC=3, CMP=4, CTRL=0x7 (write edge = E0) ----
    wr(2'd1, 16'd3);
    wr(2'd2, 16'd4);
    wr(2'd0, 16'h0007);          // now at E0+1
    step(3); check("per_tick_e3", 32'(tick_out), 32'h0);
    step(1); check("per_tick_e4", 32'(tick_out), 32'h1);
    step(1); check("per_tick_e5", 32'(tick_out), 32'h0);
    step(3); check("per_tick_e8", 32'(tick_out), 32'h1);
    step(12); check("per_irq_e20", 32'(irq), 32'h0);
    step(1);  check("per_irq_e21", 32'(irq), 32'h1);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;   // E22+1
    step(1);  check("per_ack_e23", 32'(irq), 32'h0);
    step(17); check("per_irq_e40", 32'(irq), 32'h0);
    step(1);  check("per_irq_e41", 32'(irq), 32'h1);

    // ---- collision: irq_ack during the match clk E60 ----
    step(18);                      // E59+1
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;   // E60+1
    step(1);  check("col_irq_held", 32'(irq), 32'h1);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;   // E62+1
    check("col_irq_lag", 32'(irq), 32'h1);
    step(1);  check("col_irq_clr", 32'(irq), 32'h0);
    wr(2'd0, 16'h0100);            // stop, clear PENDING
    wr(2'd3, 16'h0000);

    // ---- one-shot: PRESC=0, CMP=2, CTRL=0x5 ----
    wr(2'd1, 16'd0);
    wr(2'd2, 16'd2);
    wr(2'd0, 16'h0005);            // E0+1
    step(3); check("os_irq_e3", 32'(irq), 32'h0);
    check("os_tick_e3", 32'(tick_out), 32'h1);
    step(1); check("os_irq_e4", 32'(irq), 32'h1);
    rd(2'd0, v); check("os_ctrl", 32'(v), 32'h0304);
    for (int i = 0; i < 4; i++) begin
      step(1); check($sformatf("os_notick%0d", i), 32'(tick_out), 32'h0);
    end
    rd(2'd3, v); check("os_cnt", 32'(v), 32'h0);
    wr(2'd0, 16'h0100);            // DONE -> IDLE, clear PENDING
    rd(2'd0, v); check("os_ctrl_clr", 32'(v), 32'h0);

    // ---- wrap: PRESC=0, CMP=5, CNT=0xFFFF, EN=1 ----
    wr(2'd2, 16'd5);
    wr(2'd3, 16'hFFFF);
    wr(2'd0, 16'h0001);            // E0+1
    rd(2'd3, v); check("wrap_cnt_e0", 32'(v), 32'hFFFF);
    rd(2'd3, v); check("wrap_cnt_e1", 32'(v), 32'h0);
    step(4);                       // E6+1
    rd(2'd0, v); check("wrap_pre7", 32'(v), 32'h0001);
    rd(2'd0, v); check("wrap_post7", 32'(v), 32'h0300);
    wr(2'd0, 16'h0100);

    // ---- read latency ----
    wr(2'd2, 16'h1234);
    rd_en = 1'b1; addr = 2'd2;
    #2; check("rl_before", 32'(rdata), 32'h0300);
    step(1); rd_en = 1'b0;
    check("rl_next", 32'(rdata), 32'h1234);
    wr(2'd2, 16'h0042);
    step(3); check("rl_held", 32'(rdata), 32'h1234);

    // ---- reset mid-run ----
    wr(2'd1, 16'd1);
    wr(2'd2, 16'd0);
    wr(2'd0, 16'h0007);
    step(6);
    check("mr_irq_pre", 32'(irq), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mr_irq_async", 32'(irq), 32'h0);
    check("mr_tick_async", 32'(tick_out), 32'h0);
    step(1);
    rst = 1'b1;
    rd(2'd0, v); check("mr_ctrl", 32'(v), 32'h0);
    rd(2'd1, v); check("mr_presc", 32'(v), 32'd50000);
    rd(2'd2, v); check("mr_cmp", 32'(v), 32'hFFFF);
    rd(2'd3, v); check("mr_cnt", 32'(v), 32'h0);
    step(3); check("mr_notick", 32'(tick_out), 32'h0);
    check("mr_noirq", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
